recon_mul_11_16: RTL



---
 rtl/recon_mul_11_16.sv | 109 ++++++++++
 1 files changed

// File: rtl/recon_mul_11_16.sv
// recon_mul_11_16: rebuilds a 16-bit dividend from its divide-by-11 quotient/remainder pair,
// x = 11*q + r. The quotient goes through one 4-bit digit per cycle, LSB first, and the
// remainder seeds the carry chain. Valid/ready handshakes on both sides.
module recon_mul_11_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [12:0] q_in,
    input  logic [3:0]  r_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] x_out,
    output logic        err
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] q_reg;
    logic [3:0]  carry;
    logic        rbad;
    logic [1:0]  step;
    logic [3:0]  digit;
    logic [7:0]  prod;

    // Current quotient digit and its digit product; 11*15 + 15 = 180 fits in 8 bits.
    always_comb begin
        digit = q_reg[{step, 2'b00} +: 4];
        prod  = (8'd11 * {4'b0000, digit}) + {4'b0000, carry};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (step == 2'd3) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath: load operands on acceptance, then shift in one result digit per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= 16'd0;
            carry <= 4'd0;
            rbad  <= 1'b0;
            step  <= 2'd0;
            x_out <= 16'd0;
            err   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        q_reg <= {3'b000, q_in};
                        carry <= r_in;
                        rbad  <= (r_in > 4'd10);
                        step  <= 2'd0;
                        x_out <= 16'd0;
                    end
                end
                StBusy: begin
                    // LSB-first digits enter at the top, so after four shifts digit 0 sits at [3:0].
                    x_out <= {prod[3:0], x_out[15:4]};
                    carry <= prod[7:4];
                    step  <= step + 2'd1;
                    if (step == 2'd3) begin
                        // A carry out of the top digit means 11*q + r >= 65536.
                        err <= rbad | (prod[7:4] != 4'd0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
